// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//   rx_state_t     : frame FSM states
//   PRESCALE_*     : supported oversampling ratios
//   maj3()         : 2-of-3 majority vote
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing counter and 3-sample majority voter.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   start_det       this cycle is edge 0 of a start bit; next edge_cnt is 1
//   active          frame in progress (FSM not IDLE)
//   prescale        latched oversampling ratio P
//   rx_in           serial line
//   bit_end         edge_cnt == P-1 while active
//   sample_upd      edge_cnt == P/2+2 while active: sampled_bit_pc updates now
//   maj_bit         majority of the three captured samples
//   sampled_bit_pc  registered majority-voted bit
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start_det,
  input  logic                      active,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      rx_in,
  output logic                      bit_end,
  output logic                      sample_upd,
  output logic                      maj_bit,
  output logic                      sampled_bit_pc
);

  localparam int PW = PRESCALE_WIDTH;

  logic [PW-1:0] edge_cnt;
  logic [PW-1:0] half, last_edge, cap_lo, cap_hi, upd_edge;
  logic [2:0]    smp;

  always_comb begin
    half       = {1'b0, prescale[PW-1:1]};
    last_edge  = prescale - PW'(1);
    cap_lo     = half - PW'(1);
    cap_hi     = half + PW'(1);
    upd_edge   = half + PW'(2);
    bit_end    = active && (edge_cnt == last_edge);
    sample_upd = active && (edge_cnt == upd_edge);
    maj_bit    = maj3(smp[0], smp[1], smp[2]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt       <= '0;
      smp            <= '0;
      sampled_bit_pc <= 1'b0;
    end else begin
      // The detect cycle already counts as edge 0, so counting resumes at 1.
      // This also covers a start that lands on the previous stop's last edge.
      if (start_det)
        edge_cnt <= PW'(1);
      else if (!active || bit_end)
        edge_cnt <= '0;
      else
        edge_cnt <= edge_cnt + PW'(1);

      if (active) begin
        if (edge_cnt == cap_lo) smp[0] <= rx_in;
        if (edge_cnt == half)   smp[1] <= rx_in;
        if (edge_cnt == cap_hi) smp[2] <= rx_in;
      end

      if (sample_upd) sampled_bit_pc <= maj_bit;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detect, bit sequencing, LSB-first
// deserialisation, parity-checker handshake and end-of-frame status pulses.
// Ports:
//   CLK, RST        oversampling clock, synchronous active-high reset
//   RX_IN           serial line, idle high
//   Prescale        oversampling ratio (8/16/32), latched at start detect
//   PAR_EN          frame carries a parity bit, latched at start detect
//   par_err         combinational result from parity checker
//   P_DATA_pc       deserialised data
//   sampled_bit_pc  registered majority-voted bit
//   par_chk_en      strobe: parity bit is in sampled_bit_pc, par_err is valid
//   data_valid      pulse: good frame in P_DATA_pc
//   par_err_o       pulse: frame ended with parity error
//   stp_err_o       pulse: frame ended with stop bit 0
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      par_err,
  output logic [DATA_WIDTH-1:0]     P_DATA_pc,
  output logic                      sampled_bit_pc,
  output logic                      par_chk_en,
  output logic                      data_valid,
  output logic                      par_err_o,
  output logic                      stp_err_o
);

  localparam int PW  = PRESCALE_WIDTH;
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t      state, next_state;
  logic [PW-1:0]  p_lat;
  logic           par_en_lat;
  logic [BCW-1:0] bit_cnt;
  logic           par_flag;
  logic           start_det, active, frame_end;
  logic           bit_end, sample_upd, maj_bit;

  uart_rx_sampler #(.PRESCALE_WIDTH(PW)) u_sampler (
    .CLK            (CLK),
    .RST            (RST),
    .start_det      (start_det),
    .active         (active),
    .prescale       (p_lat),
    .rx_in          (RX_IN),
    .bit_end        (bit_end),
    .sample_upd     (sample_upd),
    .maj_bit        (maj_bit),
    .sampled_bit_pc (sampled_bit_pc)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next state: every bit-level transition happens on the bit's last edge
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (!RX_IN) next_state = START;
      START:  if (bit_end) next_state = sampled_bit_pc ? IDLE : DATA;
      DATA:   if (bit_end && (bit_cnt == BCW'(DATA_WIDTH - 1)))
                next_state = par_en_lat ? PARITY : STOP;
      PARITY: if (bit_end) next_state = STOP;
      STOP:   if (bit_end) next_state = RX_IN ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    active     = (state != IDLE);
    // A low line on the stop's last edge is the next frame's edge 0.
    start_det  = ((state == IDLE) && !RX_IN) ||
                 ((state == STOP) && bit_end && !RX_IN);
    par_chk_en = (state == PARITY) && bit_end;
    frame_end  = (state == STOP) && bit_end;
  end

  // Datapath: config latch, bit counter, shift register, parity flag, pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_lat      <= PW'(PRESCALE_8);
      par_en_lat <= 1'b0;
      bit_cnt    <= '0;
      P_DATA_pc  <= '0;
      par_flag   <= 1'b0;
      data_valid <= 1'b0;
      par_err_o  <= 1'b0;
      stp_err_o  <= 1'b0;
    end else begin
      if (start_det) begin
        p_lat      <= Prescale;
        par_en_lat <= PAR_EN;
      end

      if (state != DATA) bit_cnt <= '0;
      else if (bit_end)  bit_cnt <= bit_cnt + BCW'(1);

      if ((state == DATA) && sample_upd)
        P_DATA_pc <= {maj_bit, P_DATA_pc[DATA_WIDTH-1:1]};

      // Sticky so the verdict survives until the stop bit is judged.
      if (start_det)                  par_flag <= 1'b0;
      else if (par_chk_en && par_err) par_flag <= 1'b1;

      // Stop error outranks parity error; only clean frames raise data_valid.
      data_valid <= frame_end &&  sampled_bit_pc && !par_flag;
      par_err_o  <= frame_end &&  sampled_bit_pc &&  par_flag;
      stp_err_o  <= frame_end && !sampled_bit_pc;
    end
  end

endmodule
